sram_sample_streamer: RTL and testbench

Parametrised SRAM sample streamer for the audio path. It reads a contiguous address window from the asynchronous SRAM with configurable wait states and prefetches samples into a small FIFO. It releases one sample per rising edge of the sample tick, with one-shot or loop playback, stop/flush, and underrun reporting. It sits between the SRAM pins and the audio output register, replacing the fixed three-state, 16-bit, frame-paced reader.

---
 rtl/sram_sample_streamer.sv | 183 ++++++++++++++++++
 tb/tb_sram_sample_streamer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sample_streamer.sv
// Streams a contiguous SRAM address window into a small prefetch FIFO and
// releases one sample per rising edge of the sample tick.
module sram_sample_streamer #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] SRAM_DQ_in,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              underrun,
  output logic              busy,
  output logic              done
);

  localparam int              PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [3:0]      WAIT_LAST = 4'(WAIT_CYCLES);
  localparam logic [PTR_W:0]  FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    READ,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] addr, addr_next;
  logic [ADDR_W-1:0] win_start, win_end;
  logic              loop_flag;
  logic [3:0]        wait_cnt, wait_next;
  logic              tick_q, tick_edge;
  logic              latch_window, push, pop, pop_req, flush;
  logic              underrun_next, done_next;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              fifo_empty, fifo_full;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign tick_edge  = sample_tick & ~tick_q;

  // SRAM pins decode from registered state only.
  assign SRAM_ADDR = addr;
  assign SRAM_CE_N = !((state == FETCH) || (state == READ));
  assign SRAM_OE_N = (state != READ);
  assign SRAM_WE_N = 1'b1;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign busy      = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case can infer a latch.
    state_next   = state;
    addr_next    = addr;
    wait_next    = '0;
    latch_window = 1'b0;
    push         = 1'b0;
    flush        = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          latch_window = 1'b1;
          addr_next    = start_addr;
          state_next   = FETCH;
        end
      end
      FETCH: begin
        if (!fifo_full) state_next = READ;
      end
      READ: begin
        if (wait_cnt == WAIT_LAST) begin
          push = 1'b1;
          if (addr != win_end) begin
            addr_next  = addr + 1'b1;
            state_next = FETCH;
          end else if (loop_flag) begin
            addr_next  = win_start;
            state_next = FETCH;
          end else begin
            state_next = DRAIN;
          end
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (fifo_empty) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Stop wins over everything: drop the in-flight read and empty the FIFO.
    if (stop && (state != IDLE)) begin
      state_next = IDLE;
      addr_next  = addr;
      wait_next  = '0;
      push       = 1'b0;
      flush      = 1'b1;
    end
  end

  assign pop_req       = tick_edge && (state != IDLE) && !stop;
  assign pop           = pop_req && !fifo_empty;
  assign underrun_next = pop_req && fifo_empty;
  assign done_next     = (state == DRAIN) && fifo_empty && !stop;

  always_ff @(posedge Clk) begin
    if (reset) begin
      addr         <= '0;
      win_start    <= '0;
      win_end      <= '0;
      loop_flag    <= 1'b0;
      wait_cnt     <= '0;
      tick_q       <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      done         <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      addr         <= addr_next;
      wait_cnt     <= wait_next;
      tick_q       <= sample_tick;
      sample_valid <= pop;
      underrun     <= underrun_next;
      done         <= done_next;
      if (latch_window) begin
        win_start <= start_addr;
        win_end   <= end_addr;
        loop_flag <= loop_en;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr     <= rd_ptr + 1'b1;
          sample_out <= fifo_mem[rd_ptr];
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: FIFO storage is not reset; the count and pointers alone define what is valid.
  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr] <= SRAM_DQ_in;
  end

endmodule

// File: tb/tb_sram_sample_streamer.sv
// Directed bench for sram_sample_streamer: table-driven playback windows plus
// hand-written stop, underrun, FIFO-full and reset sequences.
module tb_sram_sample_streamer;

  localparam int ADDR_W      = 20;
  localparam int DATA_W      = 16;
  localparam int WAIT_CYCLES = 2;
  localparam int FIFO_DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic              sample_tick = 1'b0;
  logic [DATA_W-1:0] sram_dq;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid, underrun, busy, done;

  int errors = 0;
  int checks = 0;

  int valid_cnt = 0, under_cnt = 0, done_cnt = 0, oe_windows = 0, x_cnt = 0, oe_cnt = 0;
  logic oe_prev = 1'b1;
  logic [ADDR_W-1:0] addr_log [$];

  always #5 clk = ~clk;

  sram_sample_streamer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .Clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .start_addr(start_addr), .end_addr(end_addr), .sample_tick(sample_tick),
    .SRAM_DQ_in(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_CE_N(sram_ce_n),
    .SRAM_OE_N(sram_oe_n), .SRAM_WE_N(sram_we_n), .SRAM_UB_N(sram_ub_n),
    .SRAM_LB_N(sram_lb_n), .sample_out(sample_out), .sample_valid(sample_valid),
    .underrun(underrun), .busy(busy), .done(done)
  );

  function automatic logic [15:0] mem_data(input logic [19:0] a);
    case (a)
      20'h00010: return 16'h00A0;
      20'h00011: return 16'h00A1;
      20'h00012: return 16'h00A2;
      20'h00013: return 16'h00A3;
      20'h00005: return 16'h0011;
      20'h00006: return 16'h0022;
      default:   return a[15:0] ^ 16'h5A5A;
    endcase
  endfunction

  // SRAM model: data is only valid once OE_N has been low for the full access time.
  assign sram_dq = (!sram_oe_n && oe_cnt >= WAIT_CYCLES + 1) ? mem_data(sram_addr) : 16'hBAD0;

  always @(negedge clk) begin
    if (sample_valid) valid_cnt++;
    if (underrun) under_cnt++;
    if (done) done_cnt++;
    if (!sram_oe_n && oe_prev) begin
      oe_windows++;
      addr_log.push_back(sram_addr);
    end
    oe_prev = sram_oe_n;
    oe_cnt  = sram_oe_n ? 0 : oe_cnt + 1;
    if ($isunknown(sample_out)) x_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick_and_get(output logic ok, output logic [15:0] val);
    ok  = 1'b0;
    val = '0;
    @(negedge clk);
    sample_tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        ok  = 1'b1;
        val = sample_out;
        break;
      end
    end
    sample_tick = 1'b0;
  endtask

  task automatic kick(input logic [19:0] s, input logic [19:0] e, input logic lp);
    @(negedge clk);
    start_addr = s;
    end_addr   = e;
    loop_en    = lp;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_addr"},  32'(sram_addr), 32'h0);
    check({name, "_pins"},  {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n},
          32'b11100);
    check({name, "_out"},   32'(sample_out), 32'h0);
    check({name, "_flags"}, {28'd0, sample_valid, underrun, busy, done}, 32'h0);
  endtask

  typedef struct {
    logic [19:0]       s_addr;
    logic [19:0]       e_addr;
    logic              loop;
    int                n_ticks;
    logic [5:0][15:0]  exp;
    int                n_addr;
    logic [3:0][19:0]  exp_addr;
    logic              exp_done;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic        ok;
    logic [15:0] val, held;
    int          base_v, base_u, base_d, base_a, base_w;
    logic        found;

    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ok;
    logic [15:0] val, held;
    int          base_v, base_u, base_d, base_a, base_w;
    logic        found;

    vecs[0] = '{s_addr: 20'h00010, e_addr: 20'h00013, loop: 1'b0, n_ticks: 4,
                exp: {16'h0, 16'h0, 16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0},
                n_addr: 4, exp_addr: {20'h00013, 20'h00012, 20'h00011, 20'h00010},
                exp_done: 1'b1};
    vecs[1] = '{s_addr: 20'h00005, e_addr: 20'h00006, loop: 1'b1, n_ticks: 6,
                exp: {16'h0022, 16'h0011, 16'h0022, 16'h0011, 16'h0022, 16'h0011},
                n_addr: 4, exp_addr: {20'h00006, 20'h00005, 20'h00006, 20'h00005},
                exp_done: 1'b0};
    vecs[2] = '{s_addr: 20'hFFFFE, e_addr: 20'h00001, loop: 1'b0, n_ticks: 4,
                exp: {16'h0, 16'h0, 16'h5A5B, 16'h5A5A, 16'hA5A5, 16'hA5A4},
                n_addr: 4, exp_addr: {20'h00001, 20'h00000, 20'hFFFFF, 20'hFFFFE},
                exp_done: 1'b1};
    vecs[3] = '{s_addr: 20'h00020, e_addr: 20'h00020, loop: 1'b0, n_ticks: 1,
                exp: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h5A7A},
                n_addr: 1, exp_addr: {20'h0, 20'h0, 20'h0, 20'h00020},
                exp_done: 1'b1};

    // Reset state and an ignored tick in IDLE.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_values("reset");
    tick_and_get(ok, val);
    check("idle_tick_ignored", {31'd0, ok}, 32'd0);
    check("idle_tick_no_underrun", 32'(under_cnt), 32'd0);

    // Table-driven playback windows.
    for (int v = 0; v < 4; v++) begin
      base_v = valid_cnt;
      base_u = under_cnt;
      base_d = done_cnt;
      base_a = addr_log.size();
      kick(vecs[v].s_addr, vecs[v].e_addr, vecs[v].loop);
      check($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
      for (int t = 0; t < vecs[v].n_ticks; t++) begin
        repeat (45) @(negedge clk);
        tick_and_get(ok, val);
        check($sformatf("v%0d_valid%0d", v, t), {31'd0, ok}, 32'd1);
        check($sformatf("v%0d_sample%0d", v, t), 32'(val), 32'(vecs[v].exp[t]));
      end
      if (vecs[v].exp_done) begin
        wait_done($sformatf("v%0d", v));
        repeat (3) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
        pulse_stop();
        check($sformatf("v%0d_idle_after_stop", v), 32'(busy), 32'd0);
      end
      check($sformatf("v%0d_done_count", v), 32'(done_cnt - base_d), 32'(vecs[v].exp_done));
      check($sformatf("v%0d_underruns", v), 32'(under_cnt - base_u), 32'd0);
      check($sformatf("v%0d_valid_count", v), 32'(valid_cnt - base_v), 32'(vecs[v].n_ticks));
      check($sformatf("v%0d_reads", v), 32'(addr_log.size() - base_a >= vecs[v].n_addr), 32'd1);
      for (int i = 0; i < vecs[v].n_addr; i++)
        if (addr_log.size() > base_a + i)
          check($sformatf("v%0d_addr%0d", v, i), 32'(addr_log[base_a + i]),
                32'(vecs[v].exp_addr[i]));
    end

    // Stop during the second read, then replay from start_addr with a clean FIFO.
    held   = sample_out;
    base_d = done_cnt;
    kick(20'h00010, 20'h00013, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!sram_oe_n && sram_addr == 20'h00011) begin
        found = 1'b1;
        break;
      end
    end
    check("stop_reached_second_read", {31'd0, found}, 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_idle", 32'(busy), 32'd0);
    check("stop_oe_n", 32'(sram_oe_n), 32'd1);
    check("stop_ce_n", 32'(sram_ce_n), 32'd1);
    check("stop_sample_held", 32'(sample_out), 32'(held));
    repeat (5) @(negedge clk);
    check("stop_no_done", 32'(done_cnt - base_d), 32'd0);

    base_a = addr_log.size();
    @(negedge clk);
    start_addr = 20'h00010;
    end_addr   = 20'h00013;
    loop_en    = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check("restart_fifo_flushed_underrun", 32'(underrun), 32'd1);
    check("restart_fifo_flushed_no_valid", 32'(sample_valid), 32'd0);
    for (int t = 0; t < 4; t++) begin
      repeat (45) @(negedge clk);
      tick_and_get(ok, val);
      check($sformatf("restart_sample%0d", t), 32'(val), 32'(16'h00A0 + 16'(t)));
    end
    wait_done("restart");
    check("restart_first_addr", 32'(addr_log[base_a]), 32'h00010);

    // Fast ticks outrun the reader: underruns with sample_out held and never X.
    repeat (3) @(negedge clk);
    held   = sample_out;
    base_u = under_cnt;
    base_v = valid_cnt;
    kick(20'h00030, 20'h0007F, 1'b0);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check("underrun_first_tick", 32'(underrun), 32'd1);
    check("underrun_sample_held", 32'(sample_out), 32'(held));
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("underrun_many", 32'(under_cnt - base_u >= 2), 32'd1);
    check("underrun_tick_accounting", 32'((under_cnt - base_u) + (valid_cnt - base_v)), 32'd31);
    check("underrun_no_x", 32'(x_cnt), 32'd0);
    pulse_stop();

    // No ticks: exactly FIFO_DEPTH reads, then parked in FETCH.
    base_w = oe_windows;
    kick(20'h00040, 20'h00049, 1'b0);
    repeat (200) @(negedge clk);
    check("full_read_windows", 32'(oe_windows - base_w), 32'(FIFO_DEPTH));
    check("full_parked_pins", {30'd0, sram_ce_n, sram_oe_n}, 32'b01);
    check("full_busy", 32'(busy), 32'd1);
    pulse_stop();

    // Reset in the middle of a read.
    kick(20'h00010, 20'h00013, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!sram_oe_n) begin
        found = 1'b1;
        break;
      end
    end
    check("midread_reached", {31'd0, found}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("midread_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
